// File: rtl/serial_lock_ctrl_pkg.sv
// Shared types and sizing for the bit-serial combination lock controller.
package lock_pkg;
  localparam int N           = 10;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;

  localparam logic [N-1:0] DEFAULT_CODE = 10'b0000001101;

  localparam int IDX_W  = $clog2(N);
  localparam int FAIL_W = 3;
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2,
    PROG    = 2'd3
  } state_e;
endpackage

// File: rtl/serial_lock_ctrl_if.sv
// Front-end / actuator side signals of the lock controller.
interface serial_lock_ctrl_if;
  logic                       x_valid;
  logic                       x;
  logic                       relock;
  logic                       prog;
  logic                       unlock;
  logic                       vg;
  logic                       ng;
  logic                       locked_out;
  logic [lock_pkg::FAIL_W-1:0] fail_cnt;
  logic [lock_pkg::IDX_W-1:0]  bit_idx;

  modport master (
    output x_valid, x, relock, prog,
    input  unlock, vg, ng, locked_out, fail_cnt, bit_idx
  );

  modport slave (
    input  x_valid, x, relock, prog,
    output unlock, vg, ng, locked_out, fail_cnt, bit_idx
  );
endinterface

// File: rtl/serial_lock_ctrl_timer.sv
// Loadable down-counter timing the lockout; expire is high while the count sits at 1.
module lockout_timer
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);
  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == TMR_W'(1)) && !load;
endmodule

// File: rtl/serial_lock_ctrl.sv
// Bit-serial combination lock: code entry, fail counting, timed lockout, re-programming.
//   state   | meaning
//   ENTRY   | locked, comparing incoming bits against the stored code
//   OPEN    | unlocked, waiting for relock or prog
//   LOCKOUT | too many failures, ignoring input until the timer expires
//   PROG    | unlocked, shifting a new code into the shadow register
module serial_lock_ctrl
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  serial_lock_ctrl_if.slave bus
);
  state_e              state_q, state_d;
  logic [N-1:0]        code_q, code_d;
  logic [N-1:0]        shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                unlock_q, unlock_d;
  logic                vg_q, vg_d;
  logic                ng_q, ng_d;
  logic                lock_q, lock_d;
  logic [IDX_W-1:0]    bit_sel;
  logic                match;
  logic                last_bit;
  logic                tmr_load;
  logic                tmr_expire;

  assign bit_sel  = IDX_W'(N - 1) - idx_q;
  assign match    = (bus.x == code_q[bit_sel]);
  assign last_bit = (idx_q == IDX_W'(N - 1));

  lockout_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMR_W'(LOCK_CYCLES)),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTRY;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      idx_q    <= '0;
      fail_q   <= '0;
      unlock_q <= 1'b0;
      vg_q     <= 1'b0;
      ng_q     <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      unlock_q <= unlock_d;
      vg_q     <= vg_d;
      ng_q     <= ng_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (bus.x_valid) begin
          if (match) begin
            if (last_bit) begin
              state_d = OPEN;
              idx_d   = '0;
              fail_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            idx_d = '0;
            // Reaching MAX_FAIL parks the count there for the whole lockout.
            if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
              fail_d   = FAIL_W'(MAX_FAIL);
              state_d  = LOCKOUT;
              tmr_load = 1'b1;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end
      LOCKOUT: begin
        if (tmr_expire) begin
          state_d = ENTRY;
          fail_d  = '0;
          idx_d   = '0;
        end
      end
      OPEN: begin
        if (bus.relock) begin
          state_d = ENTRY;
          idx_d   = '0;
        end else if (bus.prog) begin
          state_d  = PROG;
          idx_d    = '0;
          shadow_d = '0;
        end
      end
      PROG: begin
        if (bus.relock) begin
          state_d = ENTRY;
          idx_d   = '0;
        end else if (bus.x_valid) begin
          shadow_d = {shadow_q[N-2:0], bus.x};
          if (last_bit) begin
            code_d  = {shadow_q[N-2:0], bus.x};
            state_d = ENTRY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_comb begin
    unlock_d = (state_d == OPEN) || (state_d == PROG);
    lock_d   = (state_d == LOCKOUT);
    vg_d     = 1'b0;
    ng_d     = 1'b0;
    if (bus.x_valid) begin
      if (state_q == ENTRY) begin
        vg_d = match;
        ng_d = !match;
      end else if (state_q == PROG) begin
        vg_d = !bus.relock;
      end
    end
  end

  assign bus.unlock     = unlock_q;
  assign bus.vg         = vg_q;
  assign bus.ng         = ng_q;
  assign bus.locked_out = lock_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.bit_idx    = idx_q;
endmodule

// File: tb/tb_serial_lock_ctrl.sv
// Directed bench for serial_lock_ctrl with a reference model feeding an expected-output queue.
module tb_serial_lock_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_lock_ctrl_if bus ();

  serial_lock_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       unlock;
    logic       vg;
    logic       ng;
    logic       locked;
    logic [2:0] fail;
    logic [3:0] idx;
  } exp_t;

  localparam int M_ENTRY = 0, M_OPEN = 1, M_LOCK = 2, M_PROG = 3;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_miss = 0;
  int         vg_seen = 0;
  int         ng_seen = 0;
  int         m_state;
  logic [9:0] m_code;
  logic [9:0] m_shadow;
  int         m_idx;
  int         m_fail;
  int         m_timer;
  int         lock_cycles;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = M_ENTRY;
    m_code   = 10'b0000001101;
    m_shadow = '0;
    m_idx    = 0;
    m_fail   = 0;
    m_timer  = 0;
    sb_q.delete();
  endtask

  task automatic step(input logic v, input logic xb, input logic rl, input logic pg);
    exp_t e;
    @(negedge clk);
    bus.x_valid = v;
    bus.x       = xb;
    bus.relock  = rl;
    bus.prog    = pg;
    e = '0;
    case (m_state)
      M_ENTRY: if (v) begin
        if (xb == m_code[9-m_idx]) begin
          e.vg = 1'b1;
          if (m_idx == 9) begin
            m_state = M_OPEN; m_idx = 0; m_fail = 0;
          end else m_idx++;
        end else begin
          e.ng = 1'b1;
          m_idx = 0;
          m_fail++;
          if (m_fail == 3) begin
            m_state = M_LOCK; m_timer = 16;
          end
        end
      end
      M_LOCK: begin
        if (m_timer == 1) begin
          m_state = M_ENTRY; m_fail = 0; m_idx = 0;
        end
        m_timer--;
      end
      M_OPEN: begin
        if (rl) begin
          m_state = M_ENTRY; m_idx = 0;
        end else if (pg) begin
          m_state = M_PROG; m_idx = 0; m_shadow = '0;
        end
      end
      default: begin
        if (rl) begin
          m_state = M_ENTRY; m_idx = 0;
        end else if (v) begin
          e.vg = 1'b1;
          m_shadow = {m_shadow[8:0], xb};
          if (m_idx == 9) begin
            m_code = m_shadow; m_state = M_ENTRY; m_idx = 0;
          end else m_idx++;
        end
      end
    endcase
    e.unlock = (m_state == M_OPEN) || (m_state == M_PROG);
    e.locked = (m_state == M_LOCK);
    e.fail   = 3'(m_fail);
    e.idx    = 4'(m_idx);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    vg_seen += int'(bus.vg);
    ng_seen += int'(bus.ng);
    chk("unlock", 16'(bus.unlock), 16'(e.unlock));
    chk("vg", 16'(bus.vg), 16'(e.vg));
    chk("ng", 16'(bus.ng), 16'(e.ng));
    chk("locked_out", 16'(bus.locked_out), 16'(e.locked));
    chk("fail_cnt", 16'(bus.fail_cnt), 16'(e.fail));
    chk("bit_idx", 16'(bus.bit_idx), 16'(e.idx));
  endtask

  task automatic enter(input logic [9:0] c);
    for (int i = 0; i < 10; i++) step(1'b1, c[9-i], 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_unlock"}, 16'(bus.unlock), 16'd0);
    chk({tag, "_vg"}, 16'(bus.vg), 16'd0);
    chk({tag, "_ng"}, 16'(bus.ng), 16'd0);
    chk({tag, "_locked"}, 16'(bus.locked_out), 16'd0);
    chk({tag, "_fail"}, 16'(bus.fail_cnt), 16'd0);
    chk({tag, "_idx"}, 16'(bus.bit_idx), 16'd0);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    bus.x_valid = 1'b0; bus.x = 1'b0; bus.relock = 1'b0; bus.prog = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.x_valid = 1'b0; bus.x = 1'b0; bus.relock = 1'b0; bus.prog = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: default code opens the lock
    vg_seen = 0; ng_seen = 0;
    enter(10'b0000001101);
    chk("t1_vg_count", 16'(vg_seen), 16'd10);
    chk("t1_ng_count", 16'(ng_seen), 16'd0);
    chk("t1_unlock", 16'(bus.unlock), 16'd1);
    chk("t1_fail", 16'(bus.fail_cnt), 16'd0);

    // 2: mismatch at bit 5, then correct code
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_ng", 16'(bus.ng), 16'd1);
    chk("t2_idx", 16'(bus.bit_idx), 16'd0);
    chk("t2_fail", 16'(bus.fail_cnt), 16'd1);
    enter(10'b0000001101);
    chk("t2_unlock", 16'(bus.unlock), 16'd1);

    // 3: three failures -> 16-cycle lockout
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_locked", 16'(bus.locked_out), 16'd1);
    chk("t3_fail_sat", 16'(bus.fail_cnt), 16'd3);
    lock_cycles = 1;
    vg_seen = 0; ng_seen = 0;
    for (int i = 0; i < 40 && bus.locked_out === 1'b1; i++) begin
      step(1'b1, i[0], 1'b0, 1'b0);
      if (bus.locked_out === 1'b1) lock_cycles++;
    end
    chk("t3_lock_len", 16'(lock_cycles), 16'd16);
    chk("t3_vg_in_lock", 16'(vg_seen), 16'd0);
    chk("t3_ng_in_lock", 16'(ng_seen), 16'd0);
    chk("t3_fail_after", 16'(bus.fail_cnt), 16'd0);
    enter(10'b0000001101);
    chk("t3_unlock", 16'(bus.unlock), 16'd1);

    // 4: program a new code
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_prog_unlock", 16'(bus.unlock), 16'd1);
    enter(10'b1111100000);
    chk("t4_relocked", 16'(bus.unlock), 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_old_rejected", 16'(bus.ng), 16'd1);
    enter(10'b1111100000);
    chk("t4_new_unlock", 16'(bus.unlock), 16'd1);

    // 5: reset restores default; aborted programming leaves code intact
    mid_reset("t5_rst");
    enter(10'b0000001101);
    chk("t5_default_restored", 16'(bus.unlock), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_abort_locked", 16'(bus.unlock), 16'd0);
    enter(10'b0000001101);
    chk("t5_abort_code", 16'(bus.unlock), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_coincident_vg", 16'(bus.vg), 16'd0);
    enter(10'b0000001101);
    chk("t5_no_commit", 16'(bus.unlock), 16'd1);

    // 6: asynchronous reset mid-PROG and mid-LOCKOUT
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    mid_reset("t6_prog_rst");
    enter(10'b0000001101);
    chk("t6_after_prog_rst", 16'(bus.unlock), 16'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_in_lockout", 16'(bus.locked_out), 16'd1);
    mid_reset("t6_lock_rst");
    enter(10'b0000001101);
    chk("t6_after_lock_rst", 16'(bus.unlock), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
